ysyx_23060025_wb_scoreboard: RTL and testbench

Writer-side register scoreboard. It records every in-flight GPR/CSR write when an instruction issues from IDU to EXU, and retires the record when that instruction writes back from LSU. IDU source reads are checked against the outstanding writes, and the block drives busy and stall indications back to IDU. Sits beside the decode-stage hazard logic; it is the producer-tracking counterpart of the read-side conflict/bypass check.

---
 rtl/ysyx_23060025_wb_scoreboard_if.sv | 45 ++++
 rtl/ysyx_23060025_wb_scoreboard.sv | 107 ++++++++++
 tb/tb_ysyx_23060025_wb_scoreboard.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_wb_scoreboard_if.sv
// Issue, writeback and IDU-query bundle between the pipeline and the writer-side scoreboard.
// master is the pipeline side; slave is the scoreboard.
interface ysyx_23060025_wb_scoreboard_if #(
  parameter int unsigned INFL_W = 4
);
  logic              issue_fire_i;
  logic              issue_wd_i;
  logic [4:0]        issue_wreg_i;
  logic              issue_csr_wen_i;
  logic [11:0]       issue_csr_waddr_i;
  logic              wb_valid_i;
  logic              wb_wd_i;
  logic [4:0]        wb_wreg_i;
  logic              wb_csr_wen_i;
  logic              flush_i;
  logic              idu_ren1_i;
  logic [4:0]        idu_rsc1_i;
  logic              idu_ren2_i;
  logic [4:0]        idu_rsc2_i;
  logic              idu_csr_ren_i;
  logic [11:0]       idu_csr_raddr_i;
  logic              sb_reg1_busy_o;
  logic              sb_reg2_busy_o;
  logic              sb_csr_busy_o;
  logic              sb_full_o;
  logic              sb_stall_o;
  logic [INFL_W-1:0] sb_inflight_o;
  logic              sb_err_o;

  modport master (
    output issue_fire_i, issue_wd_i, issue_wreg_i, issue_csr_wen_i, issue_csr_waddr_i,
    output wb_valid_i, wb_wd_i, wb_wreg_i, wb_csr_wen_i, flush_i,
    output idu_ren1_i, idu_rsc1_i, idu_ren2_i, idu_rsc2_i, idu_csr_ren_i, idu_csr_raddr_i,
    input  sb_reg1_busy_o, sb_reg2_busy_o, sb_csr_busy_o, sb_full_o, sb_stall_o,
    input  sb_inflight_o, sb_err_o
  );

  modport slave (
    input  issue_fire_i, issue_wd_i, issue_wreg_i, issue_csr_wen_i, issue_csr_waddr_i,
    input  wb_valid_i, wb_wd_i, wb_wreg_i, wb_csr_wen_i, flush_i,
    input  idu_ren1_i, idu_rsc1_i, idu_ren2_i, idu_rsc2_i, idu_csr_ren_i, idu_csr_raddr_i,
    output sb_reg1_busy_o, sb_reg2_busy_o, sb_csr_busy_o, sb_full_o, sb_stall_o,
    output sb_inflight_o, sb_err_o
  );
endinterface

// File: rtl/ysyx_23060025_wb_scoreboard.sv
// Writer-side scoreboard: counts outstanding GPR writes, queues pending CSR writes in order,
// and reports source busy, structural full, in-flight count and sticky protocol errors to IDU.
module ysyx_23060025_wb_scoreboard #(
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned CSR_DEPTH = 2,
  parameter int unsigned INFL_W    = 4
) (
  input logic                          clock,
  input logic                          reset,
  ysyx_23060025_wb_scoreboard_if.slave sb
);
  localparam int unsigned PtrW  = $clog2(CSR_DEPTH);
  localparam int unsigned FcntW = $clog2(CSR_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CntMax  = '1;
  localparam logic [INFL_W-1:0] InflMax = '1;
  localparam logic [FcntW-1:0]  FifoMax = FcntW'(CSR_DEPTH);

  logic [CNT_W-1:0]  cnt_q [32];
  logic [CNT_W-1:0]  cnt_d [32];
  logic [11:0]       csr_addr_q [CSR_DEPTH];
  logic [PtrW-1:0]   csr_offs [CSR_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [FcntW-1:0]  fcnt_q;
  logic [INFL_W-1:0] infl_q;
  logic              err_q;

  logic gpr_iss, gpr_wb, full, wb_infl_ok, infl_wrap, issue_ok;
  logic gpr_inc, gpr_dec_err, gpr_dec;
  logic csr_push, csr_pop_req, csr_pop_err, csr_pop, err_set;
  logic reg1_busy, reg2_busy, csr_busy;
  logic [CSR_DEPTH-1:0] csr_hit;

  assign gpr_iss = sb.issue_wd_i & (sb.issue_wreg_i != 5'd0);
  assign gpr_wb  = sb.wb_valid_i & sb.wb_wd_i & (sb.wb_wreg_i != 5'd0);

  // Fullness looks only at registered state; a same-cycle retire never frees a slot.
  assign full = (gpr_iss & (cnt_q[sb.issue_wreg_i] == CntMax)) |
                (sb.issue_csr_wen_i & (fcnt_q == FifoMax));

  assign wb_infl_ok  = sb.wb_valid_i & (infl_q != '0);
  assign infl_wrap   = sb.issue_fire_i & ~full & (infl_q == InflMax) & ~wb_infl_ok;
  assign issue_ok    = sb.issue_fire_i & ~full & ~infl_wrap;
  assign gpr_inc     = issue_ok & gpr_iss;
  assign gpr_dec_err = gpr_wb & (cnt_q[sb.wb_wreg_i] == '0);
  assign gpr_dec     = gpr_wb & ~gpr_dec_err;
  assign csr_push    = issue_ok & sb.issue_csr_wen_i;
  assign csr_pop_req = sb.wb_valid_i & sb.wb_csr_wen_i;
  assign csr_pop_err = csr_pop_req & (fcnt_q == '0);
  assign csr_pop     = csr_pop_req & ~csr_pop_err;
  assign err_set     = (sb.issue_fire_i & full) | infl_wrap | gpr_dec_err | csr_pop_err |
                       (sb.wb_valid_i & (infl_q == '0));

  always_comb begin
    for (int i = 0; i < 32; i++) cnt_d[i] = cnt_q[i];
    if (gpr_dec) cnt_d[sb.wb_wreg_i] = cnt_d[sb.wb_wreg_i] - CNT_W'(1);
    if (gpr_inc) cnt_d[sb.issue_wreg_i] = cnt_d[sb.issue_wreg_i] + CNT_W'(1);
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < CSR_DEPTH; i++) begin
      csr_offs[i] = PtrW'(i) - rptr_q;
      csr_hit[i]  = (FcntW'(csr_offs[i]) < fcnt_q) & (csr_addr_q[i] == sb.idu_csr_raddr_i);
    end
  end

  assign reg1_busy = sb.idu_ren1_i & (sb.idu_rsc1_i != 5'd0) & (cnt_q[sb.idu_rsc1_i] != '0);
  assign reg2_busy = sb.idu_ren2_i & (sb.idu_rsc2_i != 5'd0) & (cnt_q[sb.idu_rsc2_i] != '0);
  assign csr_busy  = sb.idu_csr_ren_i & (|csr_hit);

  assign sb.sb_reg1_busy_o = reg1_busy;
  assign sb.sb_reg2_busy_o = reg2_busy;
  assign sb.sb_csr_busy_o  = csr_busy;
  assign sb.sb_full_o      = full;
  assign sb.sb_stall_o     = reg1_busy | reg2_busy | csr_busy | full;
  assign sb.sb_inflight_o  = infl_q;
  assign sb.sb_err_o       = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      infl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      if (sb.flush_i) begin
        for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
        fcnt_q <= '0;
        infl_q <= '0;
      end else begin
        for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
        if (csr_push) begin
          csr_addr_q[wptr_q] <= sb.issue_csr_waddr_i;
          wptr_q             <= wptr_q + PtrW'(1);
        end
        if (csr_pop) rptr_q <= rptr_q + PtrW'(1);
        fcnt_q <= fcnt_q + FcntW'(csr_push) - FcntW'(csr_pop);
        infl_q <= infl_q + INFL_W'(issue_ok) - INFL_W'(wb_infl_ok);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060025_wb_scoreboard.sv
// Bench for the writer-side scoreboard: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue/array reference model.
module tb_ysyx_23060025_wb_scoreboard;
  localparam int CNT_MAX   = 3;
  localparam int CSR_DEPTH = 2;
  localparam int INFL_MAX  = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_23060025_wb_scoreboard_if #(.INFL_W(4)) sbif ();

  ysyx_23060025_wb_scoreboard #(
    .CNT_W    (2),
    .CSR_DEPTH(2),
    .INFL_W   (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sb   (sbif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: per-register outstanding counts, in-order CSR queue, plain counters.
  int          m_cnt [32];
  logic [11:0] m_csr [$];
  int          m_infl;
  bit          m_err;
  bit          m_valid = 1'b0;

  function automatic bit m_csr_has(input logic [11:0] a);
    foreach (m_csr[i]) if (m_csr[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clock) begin : compare
    bit e_b1, e_b2, e_csr, e_full, wb_ok, wrap, iss_ok, gw, pop;
    e_b1   = sbif.idu_ren1_i && sbif.idu_rsc1_i != 0 && m_cnt[sbif.idu_rsc1_i] != 0;
    e_b2   = sbif.idu_ren2_i && sbif.idu_rsc2_i != 0 && m_cnt[sbif.idu_rsc2_i] != 0;
    e_csr  = sbif.idu_csr_ren_i && m_csr_has(sbif.idu_csr_raddr_i);
    e_full = (sbif.issue_wd_i && sbif.issue_wreg_i != 0 && m_cnt[sbif.issue_wreg_i] == CNT_MAX)
             || (sbif.issue_csr_wen_i && m_csr.size() == CSR_DEPTH);
    if (m_valid && !reset) begin
      chk("reg1_busy", 32'(sbif.sb_reg1_busy_o), 32'(e_b1));
      chk("reg2_busy", 32'(sbif.sb_reg2_busy_o), 32'(e_b2));
      chk("csr_busy", 32'(sbif.sb_csr_busy_o), 32'(e_csr));
      chk("full", 32'(sbif.sb_full_o), 32'(e_full));
      chk("stall", 32'(sbif.sb_stall_o), 32'(e_b1 | e_b2 | e_csr | e_full));
      chk("inflight", 32'(sbif.sb_inflight_o), 32'(m_infl));
      chk("err", 32'(sbif.sb_err_o), 32'(m_err));
    end
    // Advance the model to the state the next rising edge produces.
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_csr.delete();
      m_infl  = 0;
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      wb_ok  = sbif.wb_valid_i && m_infl > 0;
      wrap   = sbif.issue_fire_i && !e_full && m_infl == INFL_MAX && !wb_ok;
      iss_ok = sbif.issue_fire_i && !e_full && !wrap;
      gw     = sbif.wb_valid_i && sbif.wb_wd_i && sbif.wb_wreg_i != 0;
      pop    = sbif.wb_valid_i && sbif.wb_csr_wen_i;
      if ((sbif.issue_fire_i && e_full) || wrap || (gw && m_cnt[sbif.wb_wreg_i] == 0) ||
          (pop && m_csr.size() == 0) || (sbif.wb_valid_i && m_infl == 0))
        m_err = 1'b1;
      if (sbif.flush_i) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_csr.delete();
        m_infl = 0;
      end else begin
        if (gw && m_cnt[sbif.wb_wreg_i] > 0) m_cnt[sbif.wb_wreg_i]--;
        if (iss_ok && sbif.issue_wd_i && sbif.issue_wreg_i != 0) m_cnt[sbif.issue_wreg_i]++;
        if (pop && m_csr.size() > 0) void'(m_csr.pop_front());
        if (iss_ok && sbif.issue_csr_wen_i) m_csr.push_back(sbif.issue_csr_waddr_i);
        m_infl = m_infl + (iss_ok ? 1 : 0) - (wb_ok ? 1 : 0);
      end
    end
  end

  task automatic clr();
    sbif.issue_fire_i = 0; sbif.issue_wd_i = 0; sbif.issue_wreg_i = '0;
    sbif.issue_csr_wen_i = 0; sbif.issue_csr_waddr_i = '0;
    sbif.wb_valid_i = 0; sbif.wb_wd_i = 0; sbif.wb_wreg_i = '0; sbif.wb_csr_wen_i = 0;
    sbif.flush_i = 0;
    sbif.idu_ren1_i = 0; sbif.idu_rsc1_i = '0; sbif.idu_ren2_i = 0; sbif.idu_rsc2_i = '0;
    sbif.idu_csr_ren_i = 0; sbif.idu_csr_raddr_i = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic iss(input logic [4:0] r);
    sbif.issue_fire_i = 1; sbif.issue_wd_i = 1; sbif.issue_wreg_i = r;
  endtask

  task automatic wb(input logic [4:0] r);
    sbif.wb_valid_i = 1; sbif.wb_wd_i = 1; sbif.wb_wreg_i = r;
  endtask

  task automatic rd1(input logic [4:0] r);
    sbif.idu_ren1_i = 1; sbif.idu_rsc1_i = r;
  endtask

  typedef struct {bit wd; logic [4:0] rg; bit csr;} rec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rec_t        pend [$];
    rec_t        r;
    logic [11:0] csr_pool [4];
    int          nreg, ncsr;
    bit          legal;
    csr_pool = '{12'h300, 12'h305, 12'h341, 12'h342};
    clr();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy1", 32'(sbif.sb_reg1_busy_o), 0);
    chk("rst_full", 32'(sbif.sb_full_o), 0);
    chk("rst_stall", 32'(sbif.sb_stall_o), 0);
    chk("rst_inflight", 32'(sbif.sb_inflight_o), 0);
    chk("rst_err", 32'(sbif.sb_err_o), 0);

    // Single x5 write tracked through issue and writeback.
    tick(); clr(); iss(5);
    tick(); clr(); rd1(5);
    @(negedge clock);
    chk("t1_busy", 32'(sbif.sb_reg1_busy_o), 1);
    chk("t1_stall", 32'(sbif.sb_stall_o), 1);
    chk("t1_inflight", 32'(sbif.sb_inflight_o), 1);
    tick(); wb(5);
    @(negedge clock);
    chk("t1_busy_in_wb_cycle", 32'(sbif.sb_reg1_busy_o), 1);
    tick(); clr(); rd1(5);
    @(negedge clock);
    chk("t1_busy_cleared", 32'(sbif.sb_reg1_busy_o), 0);
    chk("t1_inflight_zero", 32'(sbif.sb_inflight_o), 0);

    // x0 destination is never tracked.
    tick(); clr(); iss(0); rd1(0);
    tick(); clr(); rd1(0);
    @(negedge clock);
    chk("t2_x0_busy", 32'(sbif.sb_reg1_busy_o), 0);
    chk("t2_inflight", 32'(sbif.sb_inflight_o), 1);
    tick(); clr(); wb(0);
    tick(); clr();
    @(negedge clock);
    chk("t2_inflight_zero", 32'(sbif.sb_inflight_o), 0);
    chk("t2_err", 32'(sbif.sb_err_o), 0);

    // Saturate x7 and force an overflowing issue.
    repeat (3) begin tick(); clr(); iss(7); end
    tick(); clr(); iss(7); rd1(7);
    @(negedge clock);
    chk("t3_full", 32'(sbif.sb_full_o), 1);
    chk("t3_err_before", 32'(sbif.sb_err_o), 0);
    tick(); clr(); sbif.issue_wd_i = 1; sbif.issue_wreg_i = 5'd7;
    @(negedge clock);
    chk("t3_still_full", 32'(sbif.sb_full_o), 1);
    chk("t3_err_set", 32'(sbif.sb_err_o), 1);
    chk("t3_inflight", 32'(sbif.sb_inflight_o), 3);
    for (int k = 0; k < 3; k++) begin
      tick(); clr(); wb(7); rd1(7);
      @(negedge clock);
      chk("t3_busy_during_wb", 32'(sbif.sb_reg1_busy_o), 1);
    end
    tick(); clr(); rd1(7);
    @(negedge clock);
    chk("t3_busy_cleared", 32'(sbif.sb_reg1_busy_o), 0);

    // Same-cycle issue and writeback to x3.
    tick(); clr(); iss(3);
    tick(); clr(); iss(3); wb(3);
    tick(); clr(); rd1(3);
    @(negedge clock);
    chk("t4_busy", 32'(sbif.sb_reg1_busy_o), 1);
    chk("t4_inflight", 32'(sbif.sb_inflight_o), 1);
    tick(); clr(); wb(3);
    tick(); clr(); rd1(3);
    @(negedge clock);
    chk("t4_busy_cleared", 32'(sbif.sb_reg1_busy_o), 0);

    // CSR FIFO ordering and fullness.
    tick(); clr(); sbif.issue_fire_i = 1; sbif.issue_csr_wen_i = 1; sbif.issue_csr_waddr_i = 12'h300;
    tick(); clr(); sbif.issue_fire_i = 1; sbif.issue_csr_wen_i = 1; sbif.issue_csr_waddr_i = 12'h305;
    tick(); clr(); sbif.issue_csr_wen_i = 1; sbif.issue_csr_waddr_i = 12'h310;
    sbif.idu_csr_ren_i = 1; sbif.idu_csr_raddr_i = 12'h305;
    @(negedge clock);
    chk("t5_full", 32'(sbif.sb_full_o), 1);
    chk("t5_csr_busy", 32'(sbif.sb_csr_busy_o), 1);
    tick(); clr(); sbif.wb_valid_i = 1; sbif.wb_csr_wen_i = 1;
    tick(); clr(); sbif.idu_csr_ren_i = 1; sbif.idu_csr_raddr_i = 12'h300;
    @(negedge clock);
    chk("t5_300_free", 32'(sbif.sb_csr_busy_o), 0);
    #1 sbif.idu_csr_raddr_i = 12'h305;
    #1 chk("t5_305_busy", 32'(sbif.sb_csr_busy_o), 1);
    tick(); clr(); sbif.wb_valid_i = 1; sbif.wb_csr_wen_i = 1;
    tick(); clr();

    // Flush with a same-cycle issue; the sticky error survives.
    tick(); clr(); iss(1);
    tick(); clr(); iss(2);
    tick(); clr(); iss(4); sbif.issue_csr_wen_i = 1; sbif.issue_csr_waddr_i = 12'h300;
    tick(); clr(); sbif.flush_i = 1; iss(6);
    tick(); clr(); rd1(1); sbif.idu_ren2_i = 1; sbif.idu_rsc2_i = 5'd6;
    sbif.idu_csr_ren_i = 1; sbif.idu_csr_raddr_i = 12'h300;
    @(negedge clock);
    chk("t6_busy1", 32'(sbif.sb_reg1_busy_o), 0);
    chk("t6_busy2", 32'(sbif.sb_reg2_busy_o), 0);
    chk("t6_csr", 32'(sbif.sb_csr_busy_o), 0);
    chk("t6_inflight", 32'(sbif.sb_inflight_o), 0);
    chk("t6_err_kept", 32'(sbif.sb_err_o), 1);

    // In-flight counter saturation.
    tick(); clr(); reset = 1'b1;
    tick(); reset = 1'b0; sbif.issue_fire_i = 1;
    repeat (15) tick();
    @(negedge clock);
    chk("t7_inflight_max", 32'(sbif.sb_inflight_o), 15);
    chk("t7_err_before", 32'(sbif.sb_err_o), 0);
    tick(); clr();
    @(negedge clock);
    chk("t7_inflight_held", 32'(sbif.sb_inflight_o), 15);
    chk("t7_err_wrap", 32'(sbif.sb_err_o), 1);
    tick(); sbif.flush_i = 1;
    tick(); clr();
    @(negedge clock);
    chk("t7_flushed", 32'(sbif.sb_inflight_o), 0);

    // Randomized traffic, mostly legal, with occasional protocol violations.
    for (int c = 0; c < 3000; c++) begin
      tick(); clr();
      reset = 1'b0;
      if (c % 250 == 0) begin
        reset = 1'b1;
        pend.delete();
        continue;
      end
      sbif.idu_ren1_i = ($urandom_range(0, 1) != 0); sbif.idu_rsc1_i = 5'($urandom_range(0, 7));
      sbif.idu_ren2_i = ($urandom_range(0, 1) != 0); sbif.idu_rsc2_i = 5'($urandom_range(0, 7));
      sbif.idu_csr_ren_i = ($urandom_range(0, 1) != 0);
      sbif.idu_csr_raddr_i = csr_pool[$urandom_range(0, 3)];
      sbif.issue_wd_i = ($urandom_range(0, 3) != 0);
      sbif.issue_wreg_i = 5'($urandom_range(0, 7));
      sbif.issue_csr_wen_i = ($urandom_range(0, 4) == 0);
      sbif.issue_csr_waddr_i = csr_pool[$urandom_range(0, 3)];
      nreg = 0;
      ncsr = 0;
      foreach (pend[i]) begin
        if (pend[i].wd && pend[i].rg == sbif.issue_wreg_i && pend[i].rg != 0) nreg++;
        if (pend[i].csr) ncsr++;
      end
      legal = pend.size() < 8 && !(sbif.issue_wd_i && nreg >= CNT_MAX) &&
              !(sbif.issue_csr_wen_i && ncsr >= CSR_DEPTH);
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        r = pend.pop_front();
        sbif.wb_valid_i = 1; sbif.wb_wd_i = r.wd; sbif.wb_wreg_i = r.rg; sbif.wb_csr_wen_i = r.csr;
      end else if ($urandom_range(0, 49) == 0) begin
        sbif.wb_valid_i = 1; sbif.wb_wd_i = ($urandom_range(0, 1) != 0);
        sbif.wb_wreg_i = 5'($urandom_range(0, 7)); sbif.wb_csr_wen_i = ($urandom_range(0, 1) != 0);
      end
      if ((legal && $urandom_range(0, 1) != 0) || $urandom_range(0, 59) == 0) begin
        sbif.issue_fire_i = 1;
        if (legal) begin
          r.wd = sbif.issue_wd_i; r.rg = sbif.issue_wreg_i; r.csr = sbif.issue_csr_wen_i;
          pend.push_back(r);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        sbif.flush_i = 1;
        pend.delete();
      end
    end
    tick(); clr(); reset = 1'b0;
    tick();
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
